hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the Auriga 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Generates EX-stage operand forwarding selects, load-use stalls, branch-redirect flushes and data-memory wait freezes.
- Sequences the multi-cycle mul/div unit (MDU) through a start/done handshake with a timeout.
- Sits beside the datapath; drives every pipeline-register stall/flush enable.

Parameters:
- XLEN, 32, width of the stall performance counter.
- MDU_TIMEOUT, 64, MDU_WAIT cycles before abort; legal range 2..255.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  ID instruction reads rs1/rs2.
- ex_valid  in  1  EX holds a real instruction.
- ex_rs1, ex_rs2  in  5  source registers of the instruction in EX.
- ex_rd  in  5  destination register in EX.
- ex_wen  in  1  EX instruction writes rd.
- ex_is_load  in  1  EX instruction is a load.
- ex_is_mdu  in  1  EX instruction is mul/div.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- mem_rd  in  5  destination register in MEM.
- mem_wen  in  1  MEM instruction writes rd.
- wb_rd  in  5  destination register in WB.
- wb_wen  in  1  WB instruction writes rd.
- dmem_req  in  1  MEM stage has an outstanding data request.
- dmem_ack  in  1  data memory completes the request.
- mdu_done  in  1  MDU result valid, one-cycle pulse.
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 regfile, 01 MEM result, 10 WB result.
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold the PC / pipeline register.
- flush_id, flush_ex, flush_mem  out  1  load a bubble into IF/ID, ID/EX, EX/MEM.
- mdu_start  out  1  start pulse to the MDU.
- mdu_err  out  1  one-cycle pulse on MDU timeout.
- stall_cycles  out  XLEN  count of cycles with stall_if=1.

Behaviour:
- Reset state: FSM=RUN, timeout counter=0, stall_cycles=0, mdu_err=0. All combinational outputs are 0 with inputs at 0.
- Forwarding (combinational, per operand):
  - MEM match (mem_wen, mem_rd!=0, mem_rd==ex_rsX) -> 01.
  - Otherwise WB match under the same rule -> 10.
  - Otherwise 00.
  - MEM wins over WB; x0 never forwards.
- memwait = dmem_req & !dmem_ack. It has the highest priority:
  - stall_if/id/ex/mem=1; all flushes=0; mdu_start=0.
  - FSM state and timeout counter hold.
- FSM states: RUN, MDU_WAIT.
  - RUN, no memwait, ex_valid & ex_is_mdu: mdu_start=1 for exactly this cycle; stall_if/id/ex=1; flush_mem=1. Next state MDU_WAIT, counter=0.
  - MDU_WAIT, mdu_done=0: stall_if/id/ex=1, flush_mem=1, counter+1.
  - MDU_WAIT, mdu_done=1: no stall; EX advances with the result this cycle; next state RUN.
  - MDU_WAIT, counter==MDU_TIMEOUT-1 without mdu_done: mdu_err=1 (registered, appears the next cycle); flush_mem=1 and no stall this cycle; next state RUN.
  - mdu_done while in RUN is ignored.
- Load-use (RUN, no memwait, no MDU stall): condition is ex_valid & ex_is_load & ex_wen & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - Response: stall_if=1, stall_id=1, flush_ex=1 for one cycle.
  - Resolves the next cycle because the load moves to MEM.
- Branch (ex_valid & ex_branch_taken, RUN, no memwait): flush_id=1, flush_ex=1. A load-use stall in the same cycle is suppressed.
- Priority: memwait > MDU sequencing > branch flush > load-use.
- A stall and a flush are never both asserted on the same pipeline register.
- stall_cycles increments by 1 each cycle stall_if=1 and wraps from 2^XLEN-1 to 0.
- Reset assertion mid-MDU returns the FSM to RUN immediately. No mdu_err is produced.

Test Plan:
- Forwarding: ex_rs1=5, mem_rd=5/mem_wen=1, wb_rd=5/wb_wen=1 -> fwd_a_sel=01. Drop mem_wen -> 10. ex_rs1=0 with matches on x0 -> 00.
- Load-use: ex lw x7, id_rs2=7 used -> one cycle of stall_if=stall_id=flush_ex=1, then all 0. Same with ex_branch_taken=1 -> flush_id=flush_ex=1 and stall_if=0.
- MDU handshake: ex_is_mdu=1 at cycle 0; mdu_done pulsed at cycle 4.
  - mdu_start=1 only at cycle 0.
  - stall_ex=1 on cycles 0-3, 0 on cycle 4.
  - stall_cycles=4.
- MDU timeout: MDU_TIMEOUT=8, mdu_done never asserted -> stall for cycles 0-7, mdu_err=1 at cycle 9, FSM in RUN.
- Mem freeze: dmem_req=1, dmem_ack=0 for 3 cycles while MDU_WAIT and ex_branch_taken=1 -> all stalls=1, no flushes, counter frozen. On ack, MDU sequencing resumes.
- Reset mid-MDU: rst_n low at cycle 2 of MDU_WAIT -> outputs 0, stall_cycles=0, mdu_err never asserted.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the Auriga 5-stage RV32 pipeline.
// Produces EX forwarding selects, stall/flush enables and the MDU start/timeout handshake.
module hazard_ctrl #(
    parameter int XLEN        = 32,
    parameter int MDU_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rs1,
    input  logic [4:0]      ex_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_wen,
    input  logic            ex_is_load,
    input  logic            ex_is_mdu,
    input  logic            ex_branch_taken,
    input  logic [4:0]      mem_rd,
    input  logic            mem_wen,
    input  logic [4:0]      wb_rd,
    input  logic            wb_wen,
    input  logic            dmem_req,
    input  logic            dmem_ack,
    input  logic            mdu_done,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic            stall_if,
    output logic            stall_id,
    output logic            stall_ex,
    output logic            stall_mem,
    output logic            flush_id,
    output logic            flush_ex,
    output logic            flush_mem,
    output logic            mdu_start,
    output logic            mdu_err,
    output logic [XLEN-1:0] stall_cycles,
    output logic            fsm_state
);

    // MDU handshake: mdu_start is a one-cycle request issued from RUN; the MDU answers
    // with a one-cycle mdu_done. A missing answer after MDU_TIMEOUT wait cycles aborts.
    typedef enum logic {
        S_RUN      = 1'b0,
        S_MDU_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(MDU_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_d;
    logic       memwait;
    logic       load_use;

    assign memwait   = dmem_req & ~dmem_ack;
    assign fsm_state = state_q;

    assign load_use = ex_valid & ex_is_load & ex_wen & (ex_rd != 5'd0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) |
                       (id_rs2_used & (id_rs2 == ex_rd)));

    // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (mem_wen && (mem_rd != 5'd0) && (mem_rd == ex_rs1))
            fwd_a_sel = 2'b01;
        else if (wb_wen && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
            fwd_a_sel = 2'b10;
        if (mem_wen && (mem_rd != 5'd0) && (mem_rd == ex_rs2))
            fwd_b_sel = 2'b01;
        else if (wb_wen && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
            fwd_b_sel = 2'b10;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        mdu_start = 1'b0;
        if (memwait) begin
            // Whole pipe freezes; FSM and timeout counter hold, mdu_done is not consumed.
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (ex_valid && ex_is_mdu) begin
                        mdu_start = 1'b1;
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        flush_mem = 1'b1;
                        cnt_d     = 8'd0;
                        state_d   = S_MDU_WAIT;
                    end else if (ex_valid && ex_branch_taken) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                S_MDU_WAIT: begin
                    if (mdu_done) begin
                        cnt_d   = 8'd0;
                        state_d = S_RUN;
                    end else if (cnt_q == CNT_LAST) begin
                        // Abort: let the instruction leave EX, but no result reaches MEM.
                        flush_mem = 1'b1;
                        err_d     = 1'b1;
                        cnt_d     = 8'd0;
                        state_d   = S_RUN;
                    end else begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        flush_mem = 1'b1;
                        cnt_d     = cnt_q + 8'd1;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            cnt_q        <= 8'd0;
            mdu_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mdu_err <= err_d;
            if (stall_if)
                stall_cycles <= stall_cycles + XLEN'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, MDU handshake,
// MDU timeout, memory freeze and reset during an MDU wait.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_rs1_used, id_rs2_used;
    logic        ex_valid;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_wen, ex_is_load, ex_is_mdu, ex_branch_taken;
    logic [4:0]  mem_rd;
    logic        mem_wen;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic        dmem_req, dmem_ack, mdu_done;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        flush_id, flush_ex, flush_mem;
    logic        mdu_start, mdu_err;
    logic [31:0] stall_cycles;
    logic        fsm_state;

    int          checks;
    int          errors;
    logic [31:0] exp_sc;

    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, mdu_start}
    wire [7:0] ctl = {stall_if, stall_id, stall_ex, stall_mem,
                      flush_id, flush_ex, flush_mem, mdu_start};

    localparam logic [7:0] C_NONE    = 8'b0000_0000;
    localparam logic [7:0] C_MEMWAIT = 8'b1111_0000;
    localparam logic [7:0] C_MDU_GO  = 8'b1110_0011;
    localparam logic [7:0] C_MDU_WT  = 8'b1110_0010;
    localparam logic [7:0] C_MDU_TO  = 8'b0000_0010;
    localparam logic [7:0] C_LDUSE   = 8'b1100_0100;
    localparam logic [7:0] C_BRANCH  = 8'b0000_1100;

    hazard_ctrl #(.XLEN(32), .MDU_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_is_mdu(ex_is_mdu),
        .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .wb_rd(wb_rd), .wb_wen(wb_wen),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .mdu_done(mdu_done),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
        .mdu_start(mdu_start), .mdu_err(mdu_err),
        .stall_cycles(stall_cycles), .fsm_state(fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1ns after the rising edge, outputs are sampled 2ns later.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic clear_inputs;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_valid = 1'b0; ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
        ex_wen = 1'b0; ex_is_load = 1'b0; ex_is_mdu = 1'b0; ex_branch_taken = 1'b0;
        mem_rd = 5'd0; mem_wen = 1'b0; wb_rd = 5'd0; wb_wen = 1'b0;
        dmem_req = 1'b0; dmem_ack = 1'b0; mdu_done = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        exp_sc = 32'd0;
        repeat (2) @(posedge clk);
        #3;
        checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, C_NONE); end
        checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin errors++; $display("FAIL reset_fwd got %b exp 0000", {fwd_a_sel, fwd_b_sel}); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles got %0d exp 0", stall_cycles); end
        checks++; if (mdu_err !== 1'b0) begin errors++; $display("FAIL reset_mdu_err got %b exp 0", mdu_err); end
        checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL reset_fsm got %b exp 0", fsm_state); end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_forwarding;
        next_cycle(); clear_inputs();
        ex_rs1 = 5'd5; ex_rs2 = 5'd3; mem_rd = 5'd5; mem_wen = 1'b1; wb_rd = 5'd5; wb_wen = 1'b1;
        settle();
        checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL fwd_mem_wins got %b exp 01", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL fwd_b_nomatch got %b exp 00", fwd_b_sel); end
        next_cycle(); mem_wen = 1'b0; settle();
        checks++; if (fwd_a_sel !== 2'b10) begin errors++; $display("FAIL fwd_wb got %b exp 10", fwd_a_sel); end
        next_cycle(); ex_rs1 = 5'd0; mem_rd = 5'd0; mem_wen = 1'b1; wb_rd = 5'd0; settle();
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL fwd_x0 got %b exp 00", fwd_a_sel); end
        next_cycle(); ex_rs2 = 5'd9; mem_rd = 5'd9; wb_rd = 5'd9; wb_wen = 1'b0; settle();
        checks++; if (fwd_b_sel !== 2'b01) begin errors++; $display("FAIL fwd_b_mem got %b exp 01", fwd_b_sel); end
        checks++; if (fwd_a_sel !== 2'b00) begin errors++; $display("FAIL fwd_a_x0_mem got %b exp 00", fwd_a_sel); end
        next_cycle(); mem_wen = 1'b0; wb_wen = 1'b1; settle();
        checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL fwd_b_wb got %b exp 10", fwd_b_sel); end
        checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL fwd_ctl_idle got %b exp %b", ctl, C_NONE); end
    endtask

    task automatic test_load_use;
        next_cycle(); clear_inputs();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd7;
        id_rs1 = 5'd3; id_rs1_used = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        settle();
        checks++; if (ctl !== C_LDUSE) begin errors++; $display("FAIL ldu_rs2 got %b exp %b", ctl, C_LDUSE); end
        exp_sc++;
        next_cycle();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_wen = 1'b0; ex_rd = 5'd0; mem_rd = 5'd7; mem_wen = 1'b1;
        settle();
        checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL ldu_resolved got %b exp %b", ctl, C_NONE); end
        checks++; if (stall_cycles !== exp_sc) begin errors++; $display("FAIL ldu_stall_cycles got %0d exp %0d", stall_cycles, exp_sc); end
        next_cycle();
        mem_wen = 1'b0; ex_valid = 1'b1; ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd7; id_rs2_used = 1'b0;
        settle();
        checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL ldu_unused got %b exp %b", ctl, C_NONE); end
        next_cycle(); ex_rd = 5'd0; id_rs2 = 5'd0; id_rs2_used = 1'b1; settle();
        checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL ldu_x0 got %b exp %b", ctl, C_NONE); end
        next_cycle(); ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd1; ex_branch_taken = 1'b1; settle();
        checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL ldu_branch got %b exp %b", ctl, C_BRANCH); end
        next_cycle(); ex_branch_taken = 1'b0; settle();
        checks++; if (ctl !== C_LDUSE) begin errors++; $display("FAIL ldu_rs1 got %b exp %b", ctl, C_LDUSE); end
        exp_sc++;
        next_cycle(); clear_inputs(); settle();
        checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL ldu_idle got %b exp %b", ctl, C_NONE); end
    endtask

    task automatic test_mdu_handshake;
        next_cycle(); clear_inputs(); ex_valid = 1'b1; ex_is_mdu = 1'b1; settle();
        checks++; if (ctl !== C_MDU_GO) begin errors++; $display("FAIL mdu_c0 got %b exp %b", ctl, C_MDU_GO); end
        checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL mdu_c0_fsm got %b exp 0", fsm_state); end
        exp_sc++;
        for (int c = 1; c <= 3; c++) begin
            next_cycle(); settle();
            checks++; if (ctl !== C_MDU_WT) begin errors++; $display("FAIL mdu_wait_c%0d got %b exp %b", c, ctl, C_MDU_WT); end
            checks++; if (fsm_state !== 1'b1) begin errors++; $display("FAIL mdu_wait_fsm_c%0d got %b exp 1", c, fsm_state); end
            exp_sc++;
        end
        next_cycle(); mdu_done = 1'b1; settle();
        checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL mdu_done_c4 got %b exp %b", ctl, C_NONE); end
        next_cycle(); clear_inputs(); settle();
        checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL mdu_back_run got %b exp 0", fsm_state); end
        checks++; if (stall_cycles !== exp_sc) begin errors++; $display("FAIL mdu_stall_cycles got %0d exp %0d", stall_cycles, exp_sc); end
        next_cycle(); mdu_done = 1'b1; settle();
        checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL mdu_done_in_run got %b exp %b", ctl, C_NONE); end
        next_cycle(); mdu_done = 1'b0; settle();
        checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL mdu_done_in_run_fsm got %b exp 0", fsm_state); end
    endtask

    task automatic test_mdu_timeout;
        next_cycle(); clear_inputs(); ex_valid = 1'b1; ex_is_mdu = 1'b1; settle();
        checks++; if (ctl !== C_MDU_GO) begin errors++; $display("FAIL to_c0 got %b exp %b", ctl, C_MDU_GO); end
        exp_sc++;
        for (int c = 1; c <= 7; c++) begin
            next_cycle(); settle();
            checks++; if (ctl !== C_MDU_WT) begin errors++; $display("FAIL to_wait_c%0d got %b exp %b", c, ctl, C_MDU_WT); end
            checks++; if (mdu_err !== 1'b0) begin errors++; $display("FAIL to_err_early_c%0d got %b exp 0", c, mdu_err); end
            exp_sc++;
        end
        next_cycle(); clear_inputs(); settle();
        checks++; if (ctl !== C_MDU_TO) begin errors++; $display("FAIL to_c8 got %b exp %b", ctl, C_MDU_TO); end
        checks++; if (mdu_err !== 1'b0) begin errors++; $display("FAIL to_err_c8 got %b exp 0", mdu_err); end
        next_cycle(); settle();
        checks++; if (mdu_err !== 1'b1) begin errors++; $display("FAIL to_err_c9 got %b exp 1", mdu_err); end
        checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL to_fsm_c9 got %b exp 0", fsm_state); end
        checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL to_ctl_c9 got %b exp %b", ctl, C_NONE); end
        next_cycle(); settle();
        checks++; if (mdu_err !== 1'b0) begin errors++; $display("FAIL to_err_c10 got %b exp 0", mdu_err); end
        checks++; if (stall_cycles !== exp_sc) begin errors++; $display("FAIL to_stall_cycles got %0d exp %0d", stall_cycles, exp_sc); end
    endtask

    task automatic test_mem_freeze;
        next_cycle(); clear_inputs(); ex_valid = 1'b1; ex_branch_taken = 1'b1; dmem_req = 1'b1; settle();
        checks++; if (ctl !== C_MEMWAIT) begin errors++; $display("FAIL mw_run_branch got %b exp %b", ctl, C_MEMWAIT); end
        exp_sc++;
        next_cycle(); dmem_req = 1'b0; settle();
        checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL mw_branch_after got %b exp %b", ctl, C_BRANCH); end
        next_cycle(); clear_inputs(); ex_valid = 1'b1; ex_is_mdu = 1'b1; settle();
        checks++; if (ctl !== C_MDU_GO) begin errors++; $display("FAIL mw_c0 got %b exp %b", ctl, C_MDU_GO); end
        exp_sc++;
        next_cycle(); settle();
        checks++; if (ctl !== C_MDU_WT) begin errors++; $display("FAIL mw_c1 got %b exp %b", ctl, C_MDU_WT); end
        exp_sc++;
        for (int c = 2; c <= 4; c++) begin
            next_cycle(); dmem_req = 1'b1; dmem_ack = 1'b0; ex_branch_taken = 1'b1; settle();
            checks++; if (ctl !== C_MEMWAIT) begin errors++; $display("FAIL mw_freeze_c%0d got %b exp %b", c, ctl, C_MEMWAIT); end
            checks++; if (fsm_state !== 1'b1) begin errors++; $display("FAIL mw_fsm_c%0d got %b exp 1", c, fsm_state); end
            exp_sc++;
        end
        next_cycle(); dmem_ack = 1'b1; settle();
        checks++; if (ctl !== C_MDU_WT) begin errors++; $display("FAIL mw_ack_c5 got %b exp %b", ctl, C_MDU_WT); end
        exp_sc++;
        for (int c = 6; c <= 10; c++) begin
            next_cycle(); dmem_req = 1'b0; dmem_ack = 1'b0; settle();
            checks++; if (ctl !== C_MDU_WT) begin errors++; $display("FAIL mw_resume_c%0d got %b exp %b", c, ctl, C_MDU_WT); end
            exp_sc++;
        end
        next_cycle(); clear_inputs(); settle();
        checks++; if (ctl !== C_MDU_TO) begin errors++; $display("FAIL mw_timeout_c11 got %b exp %b", ctl, C_MDU_TO); end
        next_cycle(); settle();
        checks++; if (mdu_err !== 1'b1) begin errors++; $display("FAIL mw_err_c12 got %b exp 1", mdu_err); end
        checks++; if (stall_cycles !== exp_sc) begin errors++; $display("FAIL mw_stall_cycles got %0d exp %0d", stall_cycles, exp_sc); end
    endtask

    task automatic test_reset_mid_mdu;
        next_cycle(); clear_inputs(); ex_valid = 1'b1; ex_is_mdu = 1'b1;
        next_cycle();
        next_cycle(); settle();
        checks++; if (ctl !== C_MDU_WT) begin errors++; $display("FAIL rst_pre_c2 got %b exp %b", ctl, C_MDU_WT); end
        clear_inputs();
        rst_n = 1'b0;
        exp_sc = 32'd0;
        #1;
        checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL rst_mid_ctl got %b exp %b", ctl, C_NONE); end
        checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL rst_mid_fsm got %b exp 0", fsm_state); end
        checks++; if (stall_cycles !== exp_sc) begin errors++; $display("FAIL rst_mid_stall_cycles got %0d exp 0", stall_cycles); end
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            if (c == 4) rst_n = 1'b1;
            settle();
            checks++; if (mdu_err !== 1'b0) begin errors++; $display("FAIL rst_no_err_c%0d got %b exp 0", c, mdu_err); end
        end
        checks++; if (stall_cycles !== exp_sc) begin errors++; $display("FAIL rst_after_stall_cycles got %0d exp 0", stall_cycles); end
        checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL rst_after_fsm got %b exp 0", fsm_state); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu_handshake();
        test_mdu_timeout();
        test_mem_freeze();
        test_reset_mid_mdu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
